// File: rtl/ifetch_region_router_pkg.sv
// ifetch_region_router_pkg: region constants and enum shared by the fetch and data-side routers
package ifetch_region_router_pkg;
  localparam int TAG_W = 12;
  localparam logic [TAG_W-1:0] BRAM_TAG = 12'hbfc;
  typedef enum logic {REG_CACHE = 1'b0, REG_BRAM = 1'b1} region_e;
endpackage

// File: rtl/ifetch_region_router_fixed_lat_pipe.sv
// fixed_lat_pipe: LAT-deep valid shift register, oldest stage driven out
module fixed_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic in_i,
  output logic out_o
);
  logic [LAT-1:0] vpipe_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vpipe_q <= '0;
    else begin
      vpipe_q[0] <= in_i;
      for (int i = 1; i < LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end
  assign out_o = vpipe_q[LAT-1];
endmodule

// File: rtl/ifetch_region_router.sv
// ifetch_region_router: routes fetches to boot RAM or icache by address tag, in-order return with flush
module ifetch_region_router #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BRAM_AW = 12,
  parameter int BRAM_LAT = 1,
  parameter int TAG_W = ifetch_region_router_pkg::TAG_W,
  parameter logic [TAG_W-1:0] BRAM_TAG = ifetch_region_router_pkg::BRAM_TAG,
  parameter int MAX_OUT = 2
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_addr_ok,
  input  logic               cpu_flush,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_data_ok,
  output logic               bram_ce,
  output logic [BRAM_AW-1:0] bram_addr,
  input  logic [DATA_W-1:0]  bram_dout,
  output logic               cache_req,
  output logic [ADDR_W-1:0]  cache_addr,
  input  logic               cache_addr_ok,
  input  logic               cache_data_ok,
  input  logic [DATA_W-1:0]  cache_rdata
);
  import ifetch_region_router_pkg::*;
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [CW-1:0] out_q, out_d, disc_q, disc_d;
  region_e cur_q, cur_d, reg_in;
  logic can_issue, bram_v, resp, resp_v;
  assign reg_in = (cpu_addr[ADDR_W-1 -: TAG_W] == BRAM_TAG) ? REG_BRAM : REG_CACHE;
  // Switching region only once drained keeps returns ordered without reorder storage
  assign can_issue = !cpu_flush && disc_q == '0 && out_q < CW'(MAX_OUT) &&
                     (out_q == '0 || cur_q == reg_in);
  assign bram_ce = cpu_req && reg_in == REG_BRAM && can_issue;
  assign cache_req = cpu_req && reg_in == REG_CACHE && can_issue;
  assign cpu_addr_ok = bram_ce || (cache_req && cache_addr_ok);
  assign bram_addr = cpu_addr[BRAM_AW+1:2];
  assign cache_addr = cpu_addr;
  fixed_lat_pipe #(.LAT(BRAM_LAT)) u_pipe (
    .clk_i(cpu_clk_50M), .rst_n_i(cpu_rst_n), .in_i(bram_ce), .out_o(bram_v)
  );
  assign resp = (cur_q == REG_BRAM) ? bram_v : cache_data_ok;
  // Responses with nothing outstanding are stray and must not touch the counters
  assign resp_v = resp && out_q != '0;
  assign cpu_rdata = (cur_q == REG_BRAM) ? bram_dout : cache_rdata;
  assign cpu_data_ok = resp_v && disc_q == '0 && !cpu_flush;
  always_comb begin
    out_d = out_q + CW'(cpu_addr_ok) - CW'(resp_v);
    disc_d = cpu_flush ? out_q - CW'(resp_v) :
             (disc_q != '0 && resp_v) ? disc_q - CW'(1) : disc_q;
    cur_d = cpu_addr_ok ? reg_in : cur_q;
  end
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      out_q <= '0;
      disc_q <= '0;
      cur_q <= REG_CACHE;
    end else begin
      out_q <= out_d;
      disc_q <= disc_d;
      cur_q <= cur_d;
    end
  end
endmodule

// File: tb/tb_ifetch_region_router.sv
// tb_ifetch_region_router: directed stimulus, expected fetch data queued and checked by a monitor
module tb_ifetch_region_router;
  logic clk = 0, rst_n = 0, cpu_req = 0, cpu_flush = 0;
  logic [31:0] cpu_addr = '0, cpu_rdata, bram_dout, cache_addr, cache_rdata = '0;
  logic cpu_addr_ok, cpu_data_ok, bram_ce, cache_req;
  logic cache_addr_ok = 0, cache_data_ok = 0;
  logic [11:0] bram_addr;
  logic [11:0] sh [3];
  logic [31:0] sb [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ifetch_region_router #(.BRAM_LAT(3), .MAX_OUT(2)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_addr_ok(cpu_addr_ok), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata),
    .cpu_data_ok(cpu_data_ok), .bram_ce(bram_ce), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata)
  );

  // Boot RAM model: 3-cycle read latency, word at address a reads as B000_0000 | a
  always @(posedge clk) begin
    sh[0] <= bram_addr;
    sh[1] <= sh[0];
    sh[2] <= sh[1];
  end
  assign bram_dout = {20'hb0000, sh[2]};

  always @(negedge clk) begin
    if (rst_n && cpu_data_ok) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL data_ok_unexpected: got rdata %h, required no response", cpu_rdata);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (cpu_rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h, required %h", cpu_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_ok", cpu_addr_ok, 0);
    chk("rst_data_ok", cpu_data_ok, 0);
    chk("rst_bram_ce", bram_ce, 0);
    chk("rst_cache_req", cache_req, 0);
    rst_n = 1;
    // single boot RAM fetch, data three cycles after acceptance
    cpu_req = 1; cpu_addr = 32'hbfc00000; #1;
    chk("t1_bram_ce", bram_ce, 1);
    chk("t1_addr_ok", cpu_addr_ok, 1);
    chk("t1_bram_addr", bram_addr, 0);
    chk("t1_cache_req", cache_req, 0);
    sb.push_back(32'hb0000000);
    tick(); cpu_req = 0; #1;
    chk("t1_data_ok_c1", cpu_data_ok, 0);
    tick(); #1;
    chk("t1_data_ok_c2", cpu_data_ok, 0);
    tick(); #1;
    chk("t1_data_ok_c3", cpu_data_ok, 1);
    tick();
    // three back-to-back boot RAM fetches against MAX_OUT=2
    cpu_req = 1; cpu_addr = 32'hbfc00004; #1;
    chk("t2_ok_a", cpu_addr_ok, 1);
    sb.push_back(32'hb0000001);
    tick(); cpu_addr = 32'hbfc00008; #1;
    chk("t2_ok_b", cpu_addr_ok, 1);
    sb.push_back(32'hb0000002);
    tick(); cpu_addr = 32'hbfc0000c; #1;
    chk("t2_full", cpu_addr_ok, 0);
    tick(); #1;
    chk("t2_full_resp", cpu_addr_ok, 0);
    chk("t2_resp_a", cpu_data_ok, 1);
    tick(); #1;
    chk("t2_ok_c", cpu_addr_ok, 1);
    sb.push_back(32'hb0000003);
    tick(); cpu_req = 0;
    repeat (4) tick();
    // cache fetch outstanding blocks a boot RAM fetch until it returns
    cpu_req = 1; cpu_addr = 32'h80000000; cache_addr_ok = 1; #1;
    chk("t3_cache_req", cache_req, 1);
    chk("t3_ok", cpu_addr_ok, 1);
    chk("t3_cache_addr", cache_addr, 32'h80000000);
    sb.push_back(32'hc0000000);
    tick(); cpu_addr = 32'hbfc00010; cache_addr_ok = 0; #1;
    chk("t3_hold1", bram_ce, 0);
    tick(); cache_data_ok = 1; cache_rdata = 32'hc0000000; #1;
    chk("t3_hold_resp", bram_ce, 0);
    tick(); cache_data_ok = 0; #1;
    chk("t3_bram_ce", bram_ce, 1);
    chk("t3_ok_bram", cpu_addr_ok, 1);
    sb.push_back(32'hb0000004);
    tick(); cpu_req = 0;
    repeat (4) tick();
    // flush with two cache fetches outstanding
    cpu_req = 1; cpu_addr = 32'h80000004; cache_addr_ok = 1; #1;
    chk("t4_ok_a", cpu_addr_ok, 1);
    tick(); cpu_addr = 32'h80000008; #1;
    chk("t4_ok_b", cpu_addr_ok, 1);
    tick(); cpu_req = 0; cpu_flush = 1;
    tick(); cpu_flush = 0; cpu_req = 1; cpu_addr = 32'h80000010; #1;
    chk("t4_block0", cpu_addr_ok, 0);
    tick(); cache_data_ok = 1; cache_rdata = 32'hdead0001; #1;
    chk("t4_drop1", cpu_data_ok, 0);
    chk("t4_block1", cpu_addr_ok, 0);
    tick(); cache_data_ok = 0; #1;
    chk("t4_block2", cpu_addr_ok, 0);
    tick(); cache_data_ok = 1; cache_rdata = 32'hdead0002; #1;
    chk("t4_drop2", cpu_data_ok, 0);
    chk("t4_block3", cpu_addr_ok, 0);
    tick(); cache_data_ok = 0; #1;
    chk("t4_ok_after", cpu_addr_ok, 1);
    sb.push_back(32'hc0000010);
    // simultaneous accept and response at out_cnt=1
    tick(); cpu_addr = 32'h80000014; cache_data_ok = 1; cache_rdata = 32'hc0000010; #1;
    chk("t5_ok_sim", cpu_addr_ok, 1);
    chk("t5_resp_sim", cpu_data_ok, 1);
    sb.push_back(32'hc0000014);
    tick(); cache_data_ok = 0; cpu_addr = 32'h80000018; #1;
    chk("t5_ok_second", cpu_addr_ok, 1);
    sb.push_back(32'hc0000018);
    tick(); cpu_addr = 32'h8000001c; #1;
    chk("t5_full", cpu_addr_ok, 0);
    tick(); cpu_req = 0; cache_data_ok = 1; cache_rdata = 32'hc0000014;
    tick(); cache_rdata = 32'hc0000018;
    tick(); cache_rdata = 32'hbad0bad0; #1;
    chk("t5_spurious", cpu_data_ok, 0);
    tick(); cache_data_ok = 0; cpu_req = 1; cpu_addr = 32'h80000020; #1;
    chk("t5_nouf_a", cpu_addr_ok, 1);
    sb.push_back(32'hc0000020);
    tick(); cpu_addr = 32'h80000024; #1;
    chk("t5_nouf_b", cpu_addr_ok, 1);
    sb.push_back(32'hc0000024);
    tick(); cpu_addr = 32'h80000028; #1;
    chk("t5_nouf_full", cpu_addr_ok, 0);
    tick(); cpu_req = 0; cache_data_ok = 1; cache_rdata = 32'hc0000020;
    tick(); cache_rdata = 32'hc0000024;
    tick(); cache_data_ok = 0; cache_addr_ok = 0;
    // reset with boot RAM fetches in flight
    cpu_req = 1; cpu_addr = 32'hbfc00030; #1;
    chk("t6_ok_a", cpu_addr_ok, 1);
    tick(); cpu_addr = 32'hbfc00034;
    tick(); cpu_req = 0;
    tick(); rst_n = 0; #1;
    chk("t6_rst_addr_ok", cpu_addr_ok, 0);
    chk("t6_rst_data_ok", cpu_data_ok, 0);
    chk("t6_rst_bram_ce", bram_ce, 0);
    chk("t6_rst_cache_req", cache_req, 0);
    tick(); tick(); rst_n = 1; cache_data_ok = 1; cache_rdata = 32'hbad1bad1; #1;
    chk("t6_late_cache", cpu_data_ok, 0);
    tick(); cache_data_ok = 0;
    repeat (5) tick();
    cpu_req = 1; cpu_addr = 32'hbfc00040; #1;
    chk("t6_ok_after", cpu_addr_ok, 1);
    sb.push_back(32'hb0000010);
    tick(); cpu_req = 0;
    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
